led_scan_ctrl: RTL

Sequencer for the 3-to-8 LED decoder. It generates the decoder select lines A0/A1/A2 from a programmable step timer, so the 8 LEDs light one at a time in a chosen pattern: up, down, ping-pong or single sweep. It sits between the board clock/switches and the decoder's select inputs; the decoder itself is unchanged.

---
 rtl/led_scan_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/led_scan_ctrl.sv
// ============================================================================
// Module   : led_scan_ctrl
// Purpose  : Step-timed sequencer driving the select lines of a 3-to-8 LED
//            decoder in up, down, ping-pong or single-sweep patterns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_scan_ctrl #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 A0,
    output logic                 A1,
    output logic                 A2,
    output logic                 busy,
    output logic                 wrap
);

    localparam logic [1:0] C_MODE_UP    = 2'b00;
    localparam logic [1:0] C_MODE_DOWN  = 2'b01;
    localparam logic [1:0] C_MODE_PP    = 2'b10;
    localparam logic [2:0] C_IDX_MAX    = 3'd7;
    localparam logic [2:0] C_IDX_ONE    = 3'd1;
    localparam logic [DIV_WIDTH-1:0] C_CNT_ONE = DIV_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [2:0]             idx_q;
    logic [DIV_WIDTH-1:0]   cnt_q;
    logic                   dir_q;
    logic [1:0]             mode_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   busy_q;
    logic                   wrap_q;

    logic [2:0]             idx_d;
    logic                   dir_d;
    logic                   wrap_d;
    logic                   done_d;

    // Result of taking one step from the current position in the latched mode.
    always_comb begin
        idx_d  = idx_q + C_IDX_ONE;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        done_d = 1'b0;
        case (mode_q)
            C_MODE_UP: begin
                idx_d  = idx_q + C_IDX_ONE;
                wrap_d = (idx_q == C_IDX_MAX);
            end
            C_MODE_DOWN: begin
                idx_d  = idx_q - C_IDX_ONE;
                wrap_d = (idx_q == 3'd0);
            end
            C_MODE_PP: begin
                if (!dir_q) begin
                    idx_d = idx_q + C_IDX_ONE;
                    if (idx_q == 3'd6) begin
                        dir_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - C_IDX_ONE;
                    if (idx_q == 3'd1) begin
                        dir_d  = 1'b0;
                        wrap_d = 1'b1;
                    end
                end
            end
            default: begin
                // Single sweep parks on the last LED instead of wrapping.
                if (idx_q == C_IDX_MAX) begin
                    idx_d  = C_IDX_MAX;
                    wrap_d = 1'b1;
                    done_d = 1'b1;
                end else begin
                    idx_d = idx_q + C_IDX_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            div_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (en) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        mode_q  <= mode;
                        div_q   <= div;
                        if (mode == C_MODE_DOWN) begin
                            idx_q <= C_IDX_MAX;
                            dir_q <= 1'b1;
                        end else begin
                            idx_q <= 3'd0;
                            dir_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Dropping en takes priority over a coincident step.
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == div_q) begin
                        cnt_q  <= '0;
                        idx_q  <= idx_d;
                        dir_q  <= dir_d;
                        wrap_q <= wrap_d;
                        if (done_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + C_CNT_ONE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (!en) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {A2, A1, A0} = idx_q;
    assign busy         = busy_q;
    assign wrap         = wrap_q;

endmodule

`default_nettype wire
